// File: rtl/mem_slave_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory-side slave controller:
//   state_t    - controller FSM states (IDLE, WAIT, RESP)
//   LAT_W      - width of the wait-state counter (latencies 0..15)
//   WORD_BYTES - bytes per SRAM word; BYTE_OFS is its log2
//   cnt_t      - 32-bit statistics counter type
//   isIllegal  - legality check for a byte address against an SRAM depth
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int LAT_W      = 4;
  localparam int WORD_BYTES = 8;
  localparam int BYTE_OFS   = 3;

  typedef logic [31:0] cnt_t;

  // An access is illegal when it is not word aligned or when its word index
  // lies beyond the end of the SRAM.
  function automatic logic isIllegal(input logic [63:0] addr, input int unsigned depth);
    return (addr[BYTE_OFS-1:0] != '0) ||
           (addr[63:BYTE_OFS] >= (64-BYTE_OFS)'(depth));
  endfunction

endpackage

// File: rtl/mem_slave_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_slave_ctrl_if
// Request/response channel between the arbiter (master) and the memory
// slave controller (slave).
//   addr_m  - byte address          (master -> slave)
//   dout_m  - write data            (master -> slave)
//   req_m   - request valid         (master -> slave)
//   wr_m    - 1=write, 0=read       (master -> slave)
//   din_m   - read data             (slave -> master)
//   rdy_m   - one-cycle completion  (slave -> master)
//   err_m   - access error          (slave -> master)
// ---------------------------------------------------------------------------
interface mem_slave_ctrl_if;
  import mem_pkg::*;

  logic [63:0] addr_m;
  logic [63:0] dout_m;
  logic [63:0] din_m;
  logic        req_m;
  logic        wr_m;
  logic        rdy_m;
  logic        err_m;

  modport master (
    output addr_m, dout_m, req_m, wr_m,
    input  din_m, rdy_m, err_m
  );

  modport slave (
    input  addr_m, dout_m, req_m, wr_m,
    output din_m, rdy_m, err_m
  );

endinterface

// File: rtl/mem_slave_ctrl_sp_ram.sv
// ---------------------------------------------------------------------------
// sp_ram
// Synchronous single-port RAM, no reset.
//   clk   - clock
//   en    - access enable
//   we    - 1=write, 0=read (qualified by en)
//   addr  - word index
//   wdata - write data
//   rdata - read data, registered; only updated by reads so it holds the
//           last read word across writes and idle cycles
// ---------------------------------------------------------------------------
module sp_ram
  import mem_pkg::*;
#(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array plus registered read port.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_slave_ctrl.sv
// ---------------------------------------------------------------------------
// mem_slave_ctrl
// Memory-side target of the request arbiter. Captures a request, waits the
// programmed number of wait states, performs the SRAM access on the edge
// that enters RESP and answers with a one-cycle rdy_m pulse.
//   clk     - clock
//   reset   - synchronous, active-high reset
//   bus     - request/response channel (slave modport)
//   rd_cnt  - completed legal reads
//   wr_cnt  - completed legal writes
//   err_cnt - errored accesses
// ---------------------------------------------------------------------------
module mem_slave_ctrl
  import mem_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  parameter  int RD_LAT = 2,
  parameter  int WR_LAT = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  mem_slave_ctrl_if.slave  bus,
  output cnt_t             rd_cnt,
  output cnt_t             wr_cnt,
  output cnt_t             err_cnt
);

  localparam logic [LAT_W-1:0] RD_LAT_C = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] WR_LAT_C = LAT_W'(WR_LAT);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [63:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic              illegal_q, illegal_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              rdZero_q, rdZero_d;
  cnt_t              rdCnt_q, rdCnt_d;
  cnt_t              wrCnt_q, wrCnt_d;
  cnt_t              errCnt_q, errCnt_d;

  logic              ramEn;
  logic              ramWe;
  logic [AW-1:0]     ramAddr;
  logic [63:0]       ramWdata;
  logic [63:0]       ramRdata;

  sp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_ram (
    .clk   (clk),
    .en    (ramEn),
    .we    (ramWe),
    .addr  (ramAddr),
    .wdata (ramWdata),
    .rdata (ramRdata)
  );

  // Next-state logic. The access side-effects are keyed off state_d==RESP so
  // that a zero-latency request uses the live bus values (the _d copies in
  // IDLE) while a waited request uses the captured ones.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    illegal_d = illegal_q;
    lat_d     = lat_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
    rdZero_d  = rdZero_q;
    rdCnt_d   = rdCnt_q;
    wrCnt_d   = wrCnt_q;
    errCnt_d  = errCnt_q;
    ramEn     = 1'b0;
    ramWe     = 1'b0;
    ramAddr   = addr_q;
    ramWdata  = data_q;

    case (state_q)
      IDLE: begin
        if (bus.req_m) begin
          addr_d    = bus.addr_m[BYTE_OFS +: AW];
          data_d    = bus.dout_m;
          wr_d      = bus.wr_m;
          illegal_d = isIllegal(bus.addr_m, DEPTH);
          lat_d     = bus.wr_m ? WR_LAT_C : RD_LAT_C;
          state_d   = (lat_d == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LAT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (illegal_q) begin
          errCnt_d = errCnt_q + 1'b1;
        end else if (wr_q) begin
          wrCnt_d = wrCnt_q + 1'b1;
        end else begin
          rdCnt_d = rdCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering RESP: raise the response and perform the SRAM access. The
    // reset gate keeps an access from landing on a reset edge. din_m is
    // forced to zero after an illegal read; writes leave it untouched.
    if (state_d == RESP) begin
      rdy_d    = 1'b1;
      err_d    = illegal_d;
      ramAddr  = addr_d;
      ramWdata = data_d;
      ramWe    = wr_d;
      ramEn    = !illegal_d && !reset;
      if (!wr_d) begin
        rdZero_d = illegal_d;
      end
    end
  end

  // State and capture registers. The SRAM itself is not cleared by reset;
  // rdZero_q=1 makes din_m read as zero until the first legal read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
      lat_q     <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      rdZero_q  <= 1'b1;
      rdCnt_q   <= '0;
      wrCnt_q   <= '0;
      errCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      illegal_q <= illegal_d;
      lat_q     <= lat_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      rdZero_q  <= rdZero_d;
      rdCnt_q   <= rdCnt_d;
      wrCnt_q   <= wrCnt_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign bus.rdy_m = rdy_q;
  assign bus.err_m = err_q;
  assign bus.din_m = rdZero_q ? 64'd0 : ramRdata;
  assign rd_cnt    = rdCnt_q;
  assign wr_cnt    = wrCnt_q;
  assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_slave_ctrl
// Directed bench for mem_slave_ctrl. Three instances with different wait
// states: A (RD_LAT=2, WR_LAT=1), B (RD_LAT=2, WR_LAT=3), C (RD_LAT=0,
// WR_LAT=1), each with its own reset.
// ---------------------------------------------------------------------------
module tb_mem_slave_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  resetV;
  logic [2:0]  rdyV;
  logic [2:0]  errV;
  logic [63:0] dinV [3];
  cnt_t        rdCnt [3];
  cnt_t        wrCnt [3];
  cnt_t        errCnt [3];

  int errors = 0;
  int checks = 0;
  int pulses [3];
  int consec [3];
  logic [2:0] prevRdy;

  mem_slave_ctrl_if ifA ();
  mem_slave_ctrl_if ifB ();
  mem_slave_ctrl_if ifC ();

  mem_slave_ctrl #(.DEPTH(1024), .RD_LAT(2), .WR_LAT(1)) dutA (
    .clk(clk), .reset(resetV[0]), .bus(ifA.slave),
    .rd_cnt(rdCnt[0]), .wr_cnt(wrCnt[0]), .err_cnt(errCnt[0])
  );

  mem_slave_ctrl #(.DEPTH(1024), .RD_LAT(2), .WR_LAT(3)) dutB (
    .clk(clk), .reset(resetV[1]), .bus(ifB.slave),
    .rd_cnt(rdCnt[1]), .wr_cnt(wrCnt[1]), .err_cnt(errCnt[1])
  );

  mem_slave_ctrl #(.DEPTH(1024), .RD_LAT(0), .WR_LAT(1)) dutC (
    .clk(clk), .reset(resetV[2]), .bus(ifC.slave),
    .rd_cnt(rdCnt[2]), .wr_cnt(wrCnt[2]), .err_cnt(errCnt[2])
  );

  assign rdyV[0] = ifA.rdy_m;
  assign rdyV[1] = ifB.rdy_m;
  assign rdyV[2] = ifC.rdy_m;
  assign errV[0] = ifA.err_m;
  assign errV[1] = ifB.err_m;
  assign errV[2] = ifC.err_m;
  assign dinV[0] = ifA.din_m;
  assign dinV[1] = ifB.din_m;
  assign dinV[2] = ifC.din_m;

  // Count rdy pulses per instance and flag any two-cycle-wide pulse.
  initial begin
    for (int k = 0; k < 3; k++) begin
      pulses[k] = 0;
      consec[k] = 0;
    end
    prevRdy = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rdyV[k]) begin
          pulses[k]++;
          if (prevRdy[k]) consec[k]++;
        end
      end
      prevRdy = rdyV;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic driveBus(input int sel, input logic req, input logic wr,
                          input logic [63:0] addr, input logic [63:0] data);
    case (sel)
      0: begin ifA.req_m = req; ifA.wr_m = wr; ifA.addr_m = addr; ifA.dout_m = data; end
      1: begin ifB.req_m = req; ifB.wr_m = wr; ifB.addr_m = addr; ifB.dout_m = data; end
      default: begin ifC.req_m = req; ifC.wr_m = wr; ifC.addr_m = addr; ifC.dout_m = data; end
    endcase
  endtask

  // Issue one request in the current cycle (c0), hold req until rdy, then
  // drop it in the following cycle. Returns the rdy latency in cycles after
  // c0 and the err/din sampled in the rdy cycle. Ends #1 into the cycle
  // after rdy, where the counters already reflect the access.
  task automatic applyStimulus(input int sel, input logic wr, input logic [63:0] addr,
                               input logic [63:0] data, input string tag,
                               output int lat, output logic err, output logic [63:0] din);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    err  = 1'b0;
    din  = '0;
    driveBus(sel, 1'b1, wr, addr, data);
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (rdyV[sel]) begin
        seen = 1'b1;
        lat  = n;
        err  = errV[sel];
        din  = dinV[sel];
      end
    end
    checkOutput({tag, "_rdySeen"}, 64'(seen), 64'd1);
    @(posedge clk); #1;
    driveBus(sel, 1'b0, 1'b0, 64'd0, 64'd0);
    checkOutput({tag, "_rdySingle"}, 64'(rdyV[sel]), 64'd0);
  endtask

  int          lat;
  logic        err;
  logic [63:0] din;
  int          pulseBase;

  initial begin
    for (int k = 0; k < 3; k++) driveBus(k, 1'b0, 1'b0, 64'd0, 64'd0);
    resetV = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    resetV = 3'b000;

    // Reset state of instance A.
    checkOutput("rstRdy", 64'(rdyV[0]), 64'd0);
    checkOutput("rstErr", 64'(errV[0]), 64'd0);
    checkOutput("rstDin", dinV[0], 64'd0);
    checkOutput("rstRdCnt", 64'(rdCnt[0]), 64'd0);
    checkOutput("rstWrCnt", 64'(wrCnt[0]), 64'd0);
    checkOutput("rstErrCnt", 64'(errCnt[0]), 64'd0);

    // Write then read back.
    applyStimulus(0, 1'b1, 64'h40, 64'hDEADBEEF_01234567, "wr40", lat, err, din);
    checkOutput("wr40Lat", 64'(lat), 64'd2);
    checkOutput("wr40Err", 64'(err), 64'd0);
    applyStimulus(0, 1'b0, 64'h40, 64'd0, "rd40", lat, err, din);
    checkOutput("rd40Lat", 64'(lat), 64'd3);
    checkOutput("rd40Err", 64'(err), 64'd0);
    checkOutput("rd40Din", din, 64'hDEADBEEF_01234567);
    checkOutput("rd40WrCnt", 64'(wrCnt[0]), 64'd1);
    checkOutput("rd40RdCnt", 64'(rdCnt[0]), 64'd1);

    // Misaligned read.
    applyStimulus(0, 1'b0, 64'h43, 64'd0, "rd43", lat, err, din);
    checkOutput("rd43Lat", 64'(lat), 64'd3);
    checkOutput("rd43Err", 64'(err), 64'd1);
    checkOutput("rd43Din", din, 64'd0);
    checkOutput("rd43ErrCnt", 64'(errCnt[0]), 64'd1);
    checkOutput("rd43RdCnt", 64'(rdCnt[0]), 64'd1);

    // Out-of-range write must not disturb word 0.
    applyStimulus(0, 1'b1, 64'h0, 64'h11, "wr0", lat, err, din);
    checkOutput("wr0Err", 64'(err), 64'd0);
    checkOutput("wr0DinHold", din, 64'd0);
    applyStimulus(0, 1'b1, 64'h2000, 64'hFFFFFFFF_FFFFFFFF, "wrOor", lat, err, din);
    checkOutput("wrOorLat", 64'(lat), 64'd2);
    checkOutput("wrOorErr", 64'(err), 64'd1);
    checkOutput("wrOorErrCnt", 64'(errCnt[0]), 64'd2);
    applyStimulus(0, 1'b0, 64'h0, 64'd0, "rd0", lat, err, din);
    checkOutput("rd0Err", 64'(err), 64'd0);
    checkOutput("rd0Din", din, 64'h11);

    // Back-to-back with arbiter timing: drop req for one cycle in between.
    pulseBase = pulses[0];
    applyStimulus(0, 1'b1, 64'h80, 64'h2222, "b2bWr", lat, err, din);
    checkOutput("b2bWrDinHold", din, 64'h11);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 64'h80, 64'd0, "b2bRd", lat, err, din);
    checkOutput("b2bRdDin", din, 64'h2222);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("b2bPulses", 64'(pulses[0] - pulseBase), 64'd2);
    checkOutput("b2bConsec", 64'(consec[0]), 64'd0);
    checkOutput("endRdCnt", 64'(rdCnt[0]), 64'd3);
    checkOutput("endWrCnt", 64'(wrCnt[0]), 64'd3);
    checkOutput("endErrCnt", 64'(errCnt[0]), 64'd2);

    // Instance B: reset in the middle of a write's wait states.
    applyStimulus(1, 1'b1, 64'h100, 64'hAAAAAAAA_AAAAAAAA, "bOld", lat, err, din);
    checkOutput("bOldLat", 64'(lat), 64'd4);
    pulseBase = pulses[1];
    driveBus(1, 1'b1, 1'b1, 64'h100, 64'h55555555_55555555);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetV[1] = 1'b1;
    driveBus(1, 1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    resetV[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("bRstPulses", 64'(pulses[1] - pulseBase), 64'd0);
    checkOutput("bRstRdCnt", 64'(rdCnt[1]), 64'd0);
    checkOutput("bRstWrCnt", 64'(wrCnt[1]), 64'd0);
    checkOutput("bRstErrCnt", 64'(errCnt[1]), 64'd0);
    applyStimulus(1, 1'b0, 64'h100, 64'd0, "bRd", lat, err, din);
    checkOutput("bRdLat", 64'(lat), 64'd3);
    checkOutput("bRdDin", din, 64'hAAAAAAAA_AAAAAAAA);

    // Instance C: zero read wait states.
    applyStimulus(2, 1'b1, 64'h18, 64'h01234567_89ABCDEF, "cWr", lat, err, din);
    checkOutput("cWrLat", 64'(lat), 64'd2);
    applyStimulus(2, 1'b0, 64'h18, 64'd0, "cRd", lat, err, din);
    checkOutput("cRdLat", 64'(lat), 64'd1);
    checkOutput("cRdErr", 64'(err), 64'd0);
    checkOutput("cRdDin", din, 64'h01234567_89ABCDEF);
    checkOutput("cRdCnt", 64'(rdCnt[2]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
